// File: rtl/b1_dec_scan.sv
// b1_dec_scan: registered 4-to-16 one-hot decoder with a hold register,
// a load strobe and a prescaled auto-scan mode (walking one-hot position).
// All outputs are registered; enable only gates onehot_out, never state.
module b1_dec_scan #(
    parameter int PRESCALE = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        load,
    input  logic [3:0]  code_in,
    input  logic        scan_en,
    output logic [15:0] onehot_out,
    output logic [3:0]  code_out,
    output logic        valid,
    output logic        wrap
);

    // Prescaler is at least one bit wide so PRESCALE=1 still has a counter.
    localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_SCAN = 2'd2
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [3:0]      code_reg;
    logic [3:0]      code_next;
    logic [PS_W-1:0] presc_reg;
    logic [PS_W-1:0] presc_next;
    logic            wrap_next;
    logic [15:0]     onehot_next;
    logic [15:0]     onehot_reg;
    logic [3:0]      code_out_reg;
    logic            valid_reg;
    logic            wrap_reg;

    // State, counters and registered outputs; reset wins over everything.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= ST_IDLE;
            code_reg     <= 4'd0;
            presc_reg    <= '0;
            onehot_reg   <= 16'h0000;
            code_out_reg <= 4'd0;
            valid_reg    <= 1'b0;
            wrap_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            code_reg     <= code_next;
            presc_reg    <= presc_next;
            onehot_reg   <= onehot_next;
            code_out_reg <= code_next;
            valid_reg    <= (state_next != ST_IDLE);
            wrap_reg     <= wrap_next;
        end
    end

    // Next-state logic: IDLE is only re-entered through reset.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (scan_en)
                    state_next = ST_SCAN;
                else if (load)
                    state_next = ST_HOLD;
            end
            ST_HOLD: begin
                if (scan_en)
                    state_next = ST_SCAN;
            end
            ST_SCAN: begin
                if (!scan_en)
                    state_next = ST_HOLD;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Code / prescaler update: load beats a scan step, and a dropped step
    // cannot raise wrap. Entering SCAN restarts the prescaler; leaving it
    // freezes the count.
    always_comb begin
        code_next  = code_reg;
        presc_next = presc_reg;
        wrap_next  = 1'b0;
        if (load) begin
            code_next  = code_in;
            presc_next = '0;
        end else if (state_reg == ST_SCAN && state_next == ST_SCAN) begin
            if (presc_reg == PS_MAX) begin
                code_next  = code_reg + 4'd1;
                presc_next = '0;
                wrap_next  = (code_reg == 4'd15);
            end else begin
                presc_next = presc_reg + 1'b1;
            end
        end else if (state_next == ST_SCAN) begin
            presc_next = '0;
        end
    end

    // One decode comparator per output bit, gated by enable and non-IDLE.
    generate
        for (genvar gi = 0; gi < 16; gi++) begin : g_dec
            assign onehot_next[gi] = enable && (state_next != ST_IDLE) &&
                                     (code_next == 4'(gi));
        end
    endgenerate

    assign onehot_out = onehot_reg;
    assign code_out   = code_out_reg;
    assign valid      = valid_reg;
    assign wrap       = wrap_reg;

endmodule

// File: tb/tb_b1_dec_scan.sv
// Directed and random checks of b1_dec_scan at PRESCALE=4 and PRESCALE=1.
module tb_b1_dec_scan;

    logic        clock = 1'b0;
    logic        reset;
    logic        enable;
    logic        load;
    logic [3:0]  code_in;
    logic        scan_en;

    logic [15:0] oh4, oh1;
    logic [3:0]  co4, co1;
    logic        va4, va1, wr4, wr1;

    int vectors    = 0;
    int miscompares = 0;

    // Reference model state for the random phase, index 0: PRESCALE=4, 1: PRESCALE=1
    int          m_state [2];
    logic [3:0]  m_code  [2];
    int          m_presc [2];
    logic [15:0] e_oh    [2];
    logic [3:0]  e_co    [2];
    logic        e_va    [2];
    logic        e_wr    [2];

    always #5 clock = ~clock;

    b1_dec_scan #(.PRESCALE(4)) u_dut4 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .code_in(code_in), .scan_en(scan_en),
        .onehot_out(oh4), .code_out(co4), .valid(va4), .wrap(wr4)
    );

    b1_dec_scan #(.PRESCALE(1)) u_dut1 (
        .clock(clock), .reset(reset), .enable(enable), .load(load),
        .code_in(code_in), .scan_en(scan_en),
        .onehot_out(oh1), .code_out(co1), .valid(va1), .wrap(wr1)
    );

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk4(input string tag, input logic [15:0] oh, input logic [3:0] co,
                        input logic va, input logic wr);
        chk({tag, ".oh4"}, oh4, oh);
        chk({tag, ".co4"}, {12'h0, co4}, {12'h0, co});
        chk({tag, ".va4"}, {15'h0, va4}, {15'h0, va});
        chk({tag, ".wr4"}, {15'h0, wr4}, {15'h0, wr});
    endtask

    task automatic chk1(input string tag, input logic [15:0] oh, input logic [3:0] co,
                        input logic va, input logic wr);
        chk({tag, ".oh1"}, oh1, oh);
        chk({tag, ".co1"}, {12'h0, co1}, {12'h0, co});
        chk({tag, ".va1"}, {15'h0, va1}, {15'h0, va});
        chk({tag, ".wr1"}, {15'h0, wr1}, {15'h0, wr});
    endtask

    // Advance the spec-level model by one edge with the current inputs.
    task automatic model_step(input int k, input int lim);
        int ns;
        logic stepped;
        logic [3:0] old_code;
        stepped  = 1'b0;
        old_code = m_code[k];
        if (reset) begin
            m_state[k] = 0; m_code[k] = 4'd0; m_presc[k] = 0;
            e_oh[k] = 16'h0; e_co[k] = 4'd0; e_va[k] = 1'b0; e_wr[k] = 1'b0;
            return;
        end
        if (m_state[k] == 0)
            ns = scan_en ? 2 : (load ? 1 : 0);
        else
            ns = scan_en ? 2 : 1;
        if (load) begin
            m_code[k]  = code_in;
            m_presc[k] = 0;
        end else if (m_state[k] == 2 && ns == 2) begin
            if (m_presc[k] == lim - 1) begin
                m_code[k]  = m_code[k] + 4'd1;
                m_presc[k] = 0;
                stepped    = 1'b1;
            end else begin
                m_presc[k] = m_presc[k] + 1;
            end
        end else if (ns == 2) begin
            m_presc[k] = 0;
        end
        m_state[k] = ns;
        e_co[k] = m_code[k];
        e_va[k] = (ns != 0);
        e_wr[k] = stepped && (old_code == 4'd15);
        e_oh[k] = (enable && ns != 0) ? (16'h1 << m_code[k]) : 16'h0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; load = 1'b0; code_in = 4'd0; scan_en = 1'b0;

        // Reset state
        tick(); tick();
        chk4("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        chk1("reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        reset = 1'b0;
        tick();
        chk4("idle", 16'h0000, 4'd0, 1'b0, 1'b0);

        // Load 9 with enable
        load = 1'b1; code_in = 4'd9;
        tick();
        load = 1'b0; code_in = 4'd0;
        chk4("load9", 16'h0200, 4'd9, 1'b1, 1'b0);
        tick(); tick();
        chk4("hold9", 16'h0200, 4'd9, 1'b1, 1'b0);

        // Enable gating
        enable = 1'b0;
        tick();
        chk4("en_off", 16'h0000, 4'd9, 1'b1, 1'b0);
        enable = 1'b1;
        tick();
        chk4("en_on", 16'h0200, 4'd9, 1'b1, 1'b0);

        // PRESCALE=4 scan 14 -> 15 -> 0 -> 1
        load = 1'b1; code_in = 4'd14;
        tick();
        load = 1'b0;
        chk4("load14", 16'h4000, 4'd14, 1'b1, 1'b0);
        scan_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk4("scan14", 16'h4000, 4'd14, 1'b1, 1'b0);
        end
        tick();
        chk4("step15", 16'h8000, 4'd15, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk4("scan15", 16'h8000, 4'd15, 1'b1, 1'b0);
        end
        tick();
        chk4("wrap0", 16'h0001, 4'd0, 1'b1, 1'b1);
        tick();
        chk4("after_wrap", 16'h0001, 4'd0, 1'b1, 1'b0);
        tick(); tick();
        tick();
        chk4("step1", 16'h0002, 4'd1, 1'b1, 1'b0);

        // PRESCALE=1: load during scan, load on a step cycle, wrap
        load = 1'b1; code_in = 4'd5;
        tick();
        load = 1'b0;
        chk1("p1_load5", 16'h0020, 4'd5, 1'b1, 1'b0);
        tick();
        chk1("p1_step6", 16'h0040, 4'd6, 1'b1, 1'b0);
        tick();
        chk1("p1_step7", 16'h0080, 4'd7, 1'b1, 1'b0);
        load = 1'b1; code_in = 4'd3;
        tick();
        load = 1'b0;
        chk1("p1_load3", 16'h0008, 4'd3, 1'b1, 1'b0);
        tick();
        chk1("p1_step4", 16'h0010, 4'd4, 1'b1, 1'b0);
        load = 1'b1; code_in = 4'd15;
        tick();
        load = 1'b0;
        chk1("p1_load15", 16'h8000, 4'd15, 1'b1, 1'b0);
        tick();
        chk1("p1_wrap", 16'h0001, 4'd0, 1'b1, 1'b1);
        tick();
        chk1("p1_step1", 16'h0002, 4'd1, 1'b1, 1'b0);

        // Mid-scan reset, scan_en held high
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk4("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        chk1("mid_reset", 16'h0000, 4'd0, 1'b0, 1'b0);
        tick();
        chk4("reenter", 16'h0001, 4'd0, 1'b1, 1'b0);
        chk1("reenter", 16'h0001, 4'd0, 1'b1, 1'b0);
        tick();
        chk1("p1_first_step", 16'h0002, 4'd1, 1'b1, 1'b0);
        chk4("p4_wait", 16'h0001, 4'd0, 1'b1, 1'b0);
        tick(); tick();
        chk4("p4_wait", 16'h0001, 4'd0, 1'b1, 1'b0);
        tick();
        chk4("p4_first_step", 16'h0002, 4'd1, 1'b1, 1'b0);

        // Random phase against the reference model, starting from reset
        reset = 1'b1; load = 1'b0; scan_en = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_state[k] = 0; m_code[k] = 4'd0; m_presc[k] = 0;
        end
        tick();
        reset = 1'b0;
        for (int c = 0; c < 10000; c++) begin
            reset   = ($urandom_range(0, 511) == 0);
            load    = ($urandom_range(0, 7) == 0);
            code_in = 4'($urandom_range(0, 15));
            enable  = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0)
                scan_en = ~scan_en;
            model_step(0, 4);
            model_step(1, 1);
            tick();
            chk("rnd.oh4", oh4, e_oh[0]);
            chk("rnd.co4", {12'h0, co4}, {12'h0, e_co[0]});
            chk("rnd.vw4", {14'h0, va4, wr4}, {14'h0, e_va[0], e_wr[0]});
            chk("rnd.oh1", oh1, e_oh[1]);
            chk("rnd.co1", {12'h0, co1}, {12'h0, e_co[1]});
            chk("rnd.vw1", {14'h0, va1, wr1}, {14'h0, e_va[1], e_wr[1]});
            chk("inv4", {15'h0, (oh4 == 16'h0) || (oh4 == (16'h1 << co4))}, 16'h1);
            chk("inv1", {15'h0, (oh1 == 16'h0) || (oh1 == (16'h1 << co1))}, 16'h1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
